keycode_ram_arbiter: RTL and testbench

// - Shares the second port (s2) of the 256x32 dual-port keycode RAM between two Avalon-MM masters:

---
 rtl/keycode_ram_arbiter.sv | 159 +++++++++++++++
 tb/tb_keycode_ram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keycode_ram_arbiter.sv
// ---------------------------------------------------------------------------
// keycode_ram_arbiter
//
// Purpose:
//   Shares the second port (s2) of the 256x32 dual-port keycode RAM between
//   two Avalon-MM masters: requester 0 (game-logic keycode poller) and
//   requester 1 (debug/sprite controller). Arbitration is decided each cycle
//   with a sticky grant and a burst limit. Read data comes back one cycle
//   after the command and is flagged with readdatavalid.
//
// Configuration:
//   KEYCODE_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins
//   contention and the burst counter is not built (requester 1 may starve).
//   When undefined, sticky/burst-limited arbitration is used.
//
// Ports:
//   clk, reset_n            clock (also RAM clk2), async active-low reset
//   rq0_* / rq1_*           Avalon-MM slave ports for the two requesters
//                           (address, read, write, writedata, byteenable in;
//                           waitrequest, readdata, readdatavalid out)
//   ram_*                   RAM port s2 command outputs, ram_readdata input
// ---------------------------------------------------------------------------
module keycode_ram_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int AW        = 8,
    parameter int DW        = 32
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic [AW-1:0]   rq0_address,
    input  logic            rq0_read,
    input  logic            rq0_write,
    input  logic [DW-1:0]   rq0_writedata,
    input  logic [DW/8-1:0] rq0_byteenable,
    output logic            rq0_waitrequest,
    output logic [DW-1:0]   rq0_readdata,
    output logic            rq0_readdatavalid,

    input  logic [AW-1:0]   rq1_address,
    input  logic            rq1_read,
    input  logic            rq1_write,
    input  logic [DW-1:0]   rq1_writedata,
    input  logic [DW/8-1:0] rq1_byteenable,
    output logic            rq1_waitrequest,
    output logic [DW-1:0]   rq1_readdata,
    output logic            rq1_readdatavalid,

    output logic [AW-1:0]   ram_address,
    output logic            ram_chipselect,
    output logic            ram_write,
    output logic [DW-1:0]   ram_writedata,
    output logic [DW/8-1:0] ram_byteenable,
    output logic            ram_clken,
    input  logic [DW-1:0]   ram_readdata
);

    localparam logic GRANT_RQ0 = 1'b0;
    localparam logic GRANT_RQ1 = 1'b1;

    logic req0;
    logic req1;
    logic any_req;
    logic winner;
    logic sel;
    logic win_read;
    logic win_write;
    logic last_grant;
    logic rd_vld;
    logic rd_id;

    assign req0    = rq0_read | rq0_write;
    assign req1    = rq1_read | rq1_write;
    assign any_req = req0 | req1;

`ifndef KEYCODE_ARB_FIXED_PRIO_EN
    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    logic [3:0] burst_cnt;

    // Run length of consecutive grants to last_grant, saturating at the
    // limit. A grant to the other requester restarts the run at 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_cnt <= 4'd0;
        end else if (any_req) begin
            if (winner == last_grant) begin
                if (burst_cnt < BURST_LIMIT) begin
                    burst_cnt <= burst_cnt + 4'd1;
                end
            end else begin
                burst_cnt <= 4'd1;
            end
        end
    end
`endif

    // Winner selection. Under contention the current owner keeps the port
    // while its run is below the limit. burst_cnt is 0 only before the first
    // grant after reset; that case hands the port to the requester opposite
    // last_grant, so with last_grant resetting to 1 requester 0 wins first.
    always_comb begin
        winner = GRANT_RQ0;
        if (req0 && !req1) begin
            winner = GRANT_RQ0;
        end else if (req1 && !req0) begin
            winner = GRANT_RQ1;
        end else if (req0 && req1) begin
`ifdef KEYCODE_ARB_FIXED_PRIO_EN
            winner = GRANT_RQ0;
`else
            if ((burst_cnt != 4'd0) && (burst_cnt < BURST_LIMIT)) begin
                winner = last_grant;
            end else begin
                winner = ~last_grant;
            end
`endif
        end
    end

    // With no request the mux keeps pointing at the last winner, so the RAM
    // address does not toggle on idle cycles.
    assign sel       = any_req ? winner : last_grant;
    assign win_read  = (winner == GRANT_RQ1) ? rq1_read  : rq0_read;
    assign win_write = (winner == GRANT_RQ1) ? rq1_write : rq0_write;

    assign ram_address    = (sel == GRANT_RQ1) ? rq1_address    : rq0_address;
    assign ram_writedata  = (sel == GRANT_RQ1) ? rq1_writedata  : rq0_writedata;
    assign ram_byteenable = (sel == GRANT_RQ1) ? rq1_byteenable : rq0_byteenable;
    assign ram_chipselect = reset_n & any_req;
    assign ram_write      = reset_n & any_req & win_write;
    assign ram_clken      = 1'b1;

    // Idle requesters also see waitrequest high; everything stalls in reset.
    assign rq0_waitrequest = ~(reset_n & any_req & (winner == GRANT_RQ0));
    assign rq1_waitrequest = ~(reset_n & any_req & (winner == GRANT_RQ1));

    // Grant history and read-return pipeline. A read with write also set is
    // treated as a write and produces no read return.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= GRANT_RQ1;
            rd_vld     <= 1'b0;
            rd_id      <= GRANT_RQ0;
        end else begin
            rd_vld <= any_req & win_read & ~win_write;
            rd_id  <= winner;
            if (any_req) begin
                last_grant <= winner;
            end
        end
    end

    assign rq0_readdatavalid = rd_vld & (rd_id == GRANT_RQ0);
    assign rq1_readdatavalid = rd_vld & (rd_id == GRANT_RQ1);
    assign rq0_readdata      = rq0_readdatavalid ? ram_readdata : '0;
    assign rq1_readdata      = rq1_readdatavalid ? ram_readdata : '0;

endmodule

// File: tb/tb_keycode_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_keycode_ram_arbiter
//
// Purpose:
//   Drives randomized and directed Avalon-MM traffic from both requesters
//   into keycode_ram_arbiter, attaches a behavioural RAM to the s2 port, and
//   scores grants and read returns against a reference model.
//   Honours KEYCODE_ARB_FIXED_PRIO_EN for the expected arbitration.
// ---------------------------------------------------------------------------
module tb_keycode_ram_arbiter;

    localparam int MAX_BURST = 4;

    typedef struct {
        logic [31:0] data;
        int          cycle;
    } rdExp_t;

    logic        clk;
    logic        reset_n;
    logic [7:0]  rq0_address;
    logic        rq0_read;
    logic        rq0_write;
    logic [31:0] rq0_writedata;
    logic [3:0]  rq0_byteenable;
    logic        rq0_waitrequest;
    logic [31:0] rq0_readdata;
    logic        rq0_readdatavalid;
    logic [7:0]  rq1_address;
    logic        rq1_read;
    logic        rq1_write;
    logic [31:0] rq1_writedata;
    logic [3:0]  rq1_byteenable;
    logic        rq1_waitrequest;
    logic [31:0] rq1_readdata;
    logic        rq1_readdatavalid;
    logic [7:0]  ram_address;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic [3:0]  ram_byteenable;
    logic        ram_clken;
    logic [31:0] ram_readdata;

    logic [31:0] ramMem [256];
    logic [31:0] shadow [256];
    rdExp_t      q0[$];
    rdExp_t      q1[$];
    int          checks = 0;
    int          errors = 0;
    int          cycleCnt = 0;
    bit          owner;
    int          ownerRun;
    bit          dutWinner;
    logic [31:0] lastData0;
    logic [31:0] lastData1;

    keycode_ram_arbiter #(
        .MAX_BURST(MAX_BURST),
        .AW(8),
        .DW(32)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rq0_address(rq0_address),
        .rq0_read(rq0_read),
        .rq0_write(rq0_write),
        .rq0_writedata(rq0_writedata),
        .rq0_byteenable(rq0_byteenable),
        .rq0_waitrequest(rq0_waitrequest),
        .rq0_readdata(rq0_readdata),
        .rq0_readdatavalid(rq0_readdatavalid),
        .rq1_address(rq1_address),
        .rq1_read(rq1_read),
        .rq1_write(rq1_write),
        .rq1_writedata(rq1_writedata),
        .rq1_byteenable(rq1_byteenable),
        .rq1_waitrequest(rq1_waitrequest),
        .rq1_readdata(rq1_readdata),
        .rq1_readdatavalid(rq1_readdatavalid),
        .ram_address(ram_address),
        .ram_chipselect(ram_chipselect),
        .ram_write(ram_write),
        .ram_writedata(ram_writedata),
        .ram_byteenable(ram_byteenable),
        .ram_clken(ram_clken),
        .ram_readdata(ram_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Behavioural RAM on s2: one-cycle registered read, byte-lane writes.
    always @(posedge clk) begin
        if (ram_chipselect && ram_clken) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byteenable[b]) ramMem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
                end
            end else begin
                ram_readdata <= ramMem[ram_address];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Reference arbitration: lone requester wins; under contention the owner
    // keeps the port until it has had MAX_BURST grants in a row, and before
    // anyone has owned it the port goes to requester 0.
    function automatic bit modelWinner(input bit r0, input bit r1);
        if (r0 && !r1) return 1'b0;
        if (r1 && !r0) return 1'b1;
`ifdef KEYCODE_ARB_FIXED_PRIO_EN
        return 1'b0;
`else
        if (ownerRun > 0 && ownerRun < MAX_BURST) return owner;
        return !owner;
`endif
    endfunction

    task automatic modelReset();
        owner    = 1'b1;
        ownerRun = 0;
        q0.delete();
        q1.delete();
    endtask

    // Issue one cycle of commands, check the grant, and push expected reads.
    task automatic applyStimulus(input bit r0, input bit w0, input logic [7:0] a0, input logic [31:0] d0,
                                 input logic [3:0] be0, input bit r1, input bit w1, input logic [7:0] a1,
                                 input logic [31:0] d1, input logic [3:0] be1);
        bit     anyReq;
        bit     win;
        bit     isWrite;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        rdExp_t e;
        @(posedge clk);
        #1;
        rq0_read = r0; rq0_write = w0; rq0_address = a0; rq0_writedata = d0; rq0_byteenable = be0;
        rq1_read = r1; rq1_write = w1; rq1_address = a1; rq1_writedata = d1; rq1_byteenable = be1;
        #1;
        anyReq = r0 | w0 | r1 | w1;
        win    = modelWinner(r0 | w0, r1 | w1);
        checkOutput("waitrequest0", 32'(rq0_waitrequest), 32'(!(anyReq && !win)));
        checkOutput("waitrequest1", 32'(rq1_waitrequest), 32'(!(anyReq && win)));
        checkOutput("chipselect", 32'(ram_chipselect), 32'(anyReq));
        dutWinner = rq0_waitrequest;
        if (anyReq) begin
            addr    = win ? a1 : a0;
            isWrite = win ? w1 : w0;
            wdata   = win ? d1 : d0;
            be      = win ? be1 : be0;
            checkOutput("ramAddress", 32'(ram_address), 32'(addr));
            checkOutput("ramWrite", 32'(ram_write), 32'(isWrite));
            if (isWrite) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) shadow[addr][b*8 +: 8] = wdata[b*8 +: 8];
                end
            end else begin
                e.data  = shadow[addr];
                e.cycle = cycleCnt;
                if (win) q1.push_back(e);
                else q0.push_back(e);
            end
            if (win == owner) ownerRun = (ownerRun < MAX_BURST) ? ownerRun + 1 : MAX_BURST;
            else ownerRun = 1;
            owner = win;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 8'h00, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0, 4'h0);
        @(negedge clk);
        #1;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        rq0_read = 1'b1; rq0_write = 1'b0; rq0_address = 8'h01; rq0_writedata = '0; rq0_byteenable = 4'hF;
        rq1_read = 1'b1; rq1_write = 1'b0; rq1_address = 8'h02; rq1_writedata = '0; rq1_byteenable = 4'hF;
        modelReset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("resetWaitrequest0", 32'(rq0_waitrequest), 32'd1);
            checkOutput("resetWaitrequest1", 32'(rq1_waitrequest), 32'd1);
            checkOutput("resetChipselect", 32'(ram_chipselect), 32'd0);
        end
        rq0_read = 1'b0;
        rq1_read = 1'b0;
        reset_n  = 1'b1;
    endtask

    // Scoreboard side: pop the expectation for a port and compare.
    task automatic scorePort(input int id, input logic v, input logic [31:0] d);
        bit     have;
        rdExp_t e;
        have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (id == 0) ? q0[0] : q1[0];
        if (v) begin
            if (id == 0) lastData0 = d;
            else lastData1 = d;
            if (!have) begin
                checkOutput($sformatf("unexpectedValid%0d", id), 32'(v), 32'd0);
            end else begin
                checkOutput($sformatf("readdata%0d", id), d, e.data);
                if (id == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end
        end else if (have && e.cycle == cycleCnt - 1) begin
            checkOutput($sformatf("missingValid%0d", id), 32'(v), 32'd1);
            if (id == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
        end
    endtask

    // Monitor: samples read returns on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            checkOutput("resetValid0", 32'(rq0_readdatavalid), 32'd0);
            checkOutput("resetValid1", 32'(rq1_readdatavalid), 32'd0);
        end else begin
            scorePort(0, rq0_readdatavalid, rq0_readdata);
            scorePort(1, rq1_readdatavalid, rq1_readdata);
        end
    end

    initial begin
        int expWin;
        for (int i = 0; i < 256; i++) begin
            ramMem[i] = 32'hA500_0000 | (i * 32'h0001_0101);
            shadow[i] = ramMem[i];
        end
        ramMem[3]  = 32'h0000_001A;  shadow[3]  = 32'h0000_001A;
        ramMem[16] = 32'h1122_3344;  shadow[16] = 32'h1122_3344;
        lastData0 = '0;
        lastData1 = '0;

        doReset();

        $display("[TB] single read");
        applyStimulus(1, 0, 8'h03, 32'h0, 4'hF, 0, 0, 8'h00, 32'h0, 4'h0);
        checkOutput("singleReadGrant", 32'(rq0_waitrequest), 32'd0);
        idle(1);
        checkOutput("singleReadData", lastData0, 32'h0000_001A);

        $display("[TB] write then read");
        applyStimulus(0, 0, 8'h00, 32'h0, 4'h0, 0, 1, 8'h10, 32'hDEAD_BEEF, 4'h3);
        applyStimulus(0, 0, 8'h00, 32'h0, 4'h0, 1, 0, 8'h10, 32'h0, 4'hF);
        idle(1);
        checkOutput("writeReadData", lastData1, 32'h1122_BEEF);

        $display("[TB] read plus write");
        applyStimulus(1, 1, 8'h20, 32'hCAFE_F00D, 4'hF, 0, 0, 8'h00, 32'h0, 4'h0);
        checkOutput("readWriteRamWrite", 32'(ram_write), 32'd1);
        applyStimulus(1, 0, 8'h20, 32'h0, 4'hF, 0, 0, 8'h00, 32'h0, 4'h0);
        idle(1);
        checkOutput("readWriteData", lastData0, 32'hCAFE_F00D);

        $display("[TB] contention from reset");
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, 8'(i), 32'h0, 4'hF, 1, 0, 8'(i + 64), 32'h0, 4'hF);
`ifdef KEYCODE_ARB_FIXED_PRIO_EN
            expWin = 0;
`else
            expWin = (i / MAX_BURST) % 2;
`endif
            checkOutput($sformatf("grantOrder%0d", i), 32'(dutWinner), 32'(expWin));
        end
        idle(2);

        $display("[TB] reset during read");
        applyStimulus(1, 0, 8'h05, 32'h0, 4'hF, 0, 0, 8'h00, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        rq0_read = 1'b0;
        modelReset();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        idle(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            int  k0, k1;
            k0 = $urandom_range(0, 9);
            k1 = $urandom_range(0, 9);
            applyStimulus(k0 inside {[4:7], 9}, k0 >= 8, 8'($urandom_range(0, 15)), $urandom,
                          4'($urandom_range(0, 15)),
                          k1 inside {[4:7], 9}, k1 >= 8, 8'($urandom_range(0, 15)), $urandom,
                          4'($urandom_range(0, 15)));
        end
        idle(3);

        checkOutput("pendingReads0", 32'(q0.size()), 32'd0);
        checkOutput("pendingReads1", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
